// File: rtl/dff_bist.sv
// rtl/dff_bist.sv - BIST driver/checker for a single-bit D flip-flop under test
// Drives the flop's reset and an LFSR data stream, predicts q and reports pass/fail.
module dff_bist #(
  parameter int unsigned NUM_VECTORS = 64,
  parameter int unsigned RST_CYCLES  = 2,
  parameter logic [7:0]  LFSR_SEED   = 8'h01,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned IDX_W       = $clog2(NUM_VECTORS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             q,
  output logic             dut_rst_n,
  output logic             d,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [IDX_W-1:0] first_err_idx
);

  typedef enum logic [2:0] {
    S_IDLE, S_RST_ASSERT, S_RST_CHK, S_RUN, S_DRAIN, S_DONE
  } state_e;

  localparam logic [7:0]       SEED     = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam int unsigned      PH_MAX   = (NUM_VECTORS > RST_CYCLES) ? NUM_VECTORS : RST_CYCLES;
  localparam int unsigned      PH_W     = $clog2(PH_MAX + 1);
  localparam logic [PH_W-1:0]  RST_LAST = PH_W'(RST_CYCLES - 1);
  localparam logic [PH_W-1:0]  RUN_LAST = PH_W'(NUM_VECTORS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e           state_q, state_d;
  logic [PH_W-1:0]  ph_q, ph_d;
  logic [7:0]       lfsr_q, lfsr_d;
  logic             d_q, d_d;
  logic             dut_rst_n_q, dut_rst_n_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             exp_q, exp_d;
  logic             cmp_en_q, cmp_en_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [IDX_W-1:0] first_q, first_d;
  logic [IDX_W-1:0] chk_idx_q, chk_idx_d;

  logic             accept;
  logic             chk_act;
  logic             chk_ref;
  logic             mismatch;
  logic [IDX_W-1:0] chk_num;

  assign accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ph_q    <= '0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
    end
  end

  // ph_q counts cycles spent in the current state and restarts on every transition.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_RST_ASSERT;
      S_RST_ASSERT:   if (ph_q == RST_LAST) state_d = S_RST_CHK;
      S_RST_CHK:      state_d = S_RUN;
      S_RUN:          if (ph_q == RUN_LAST) state_d = S_DRAIN;
      S_DRAIN:        state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
    ph_d = (state_d != state_q) ? '0 : ph_q + PH_W'(1);
  end

  // Reset check (index 0) and vector checks never overlap in time.
  always_comb begin
    chk_act = 1'b0;
    chk_ref = 1'b0;
    chk_num = '0;
    if (state_q == S_RST_CHK) begin
      chk_act = 1'b1;
    end else if (cmp_en_q) begin
      chk_act = 1'b1;
      chk_ref = exp_q;
      chk_num = chk_idx_q + IDX_W'(1);
    end
  end

  assign mismatch = chk_act && (q != chk_ref);

  always_comb begin
    lfsr_d      = lfsr_q;
    d_d         = 1'b0;
    dut_rst_n_d = (state_d != S_RST_ASSERT);
    busy_d      = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d      = (state_d == S_DONE);
    pass_d      = pass_q;
    exp_d       = d_q;
    cmp_en_d    = (state_q == S_RUN);
    err_d       = err_q;
    first_d     = first_q;
    chk_idx_d   = chk_idx_q;
    if (accept) begin
      lfsr_d    = SEED;
      pass_d    = 1'b0;
      err_d     = '0;
      first_d   = '0;
      chk_idx_d = '0;
    end
    if (state_d == S_RUN) begin
      d_d    = lfsr_q[0];
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
    if (cmp_en_q) chk_idx_d = chk_idx_q + IDX_W'(1);
    if (mismatch) begin
      if (err_q == '0) first_d = chk_num;
      if (err_q != CNT_MAX) err_d = err_q + CNT_W'(1);
    end
    if (state_q == S_DRAIN) pass_d = (err_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q      <= SEED;
      d_q         <= 1'b0;
      dut_rst_n_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      exp_q       <= 1'b0;
      cmp_en_q    <= 1'b0;
      err_q       <= '0;
      first_q     <= '0;
      chk_idx_q   <= '0;
    end else begin
      lfsr_q      <= lfsr_d;
      d_q         <= d_d;
      dut_rst_n_q <= dut_rst_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      exp_q       <= exp_d;
      cmp_en_q    <= cmp_en_d;
      err_q       <= err_d;
      first_q     <= first_d;
      chk_idx_q   <= chk_idx_d;
    end
  end

  assign dut_rst_n     = dut_rst_n_q;
  assign d             = d_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_count     = err_q;
  assign first_err_idx = first_q;

endmodule

// File: tb/tb_dff_bist.sv
// tb/tb_dff_bist.sv - scoreboard bench for dff_bist with ideal, stuck and inverting flops
module tb_dff_bist;
  localparam int NA = 64,  RA = 2;
  localparam int NB = 255, RB = 2;
  localparam int NC = 255, RC = 3;

  typedef struct {
    int done_cyc;
    int pass;
    int err;
    int first;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  logic       rst_n_a, start_a, q_a, dut_rst_n_a, d_a, busy_a, done_a, pass_a;
  logic [7:0] err_a;
  logic [6:0] first_a;
  logic       rst_n_bc, start_b, q_b, r_b, dut_rst_n_b, d_b, busy_b, done_b, pass_b;
  logic [7:0] err_b, first_b;
  logic       start_c, q_c, r_c, dut_rst_n_c, d_c, busy_c, done_c, pass_c;
  logic [3:0] err_c;
  logic [7:0] first_c;
  int         mode_b = 0, mode_c = 0;   // 0 ideal, 1 stuck-0, 2 stuck-1, 3 inverting

  dff_bist u_a (
    .clk(clk), .rst_n(rst_n_a), .start(start_a), .q(q_a), .dut_rst_n(dut_rst_n_a), .d(d_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a), .first_err_idx(first_a));

  dff_bist #(.NUM_VECTORS(NB), .RST_CYCLES(RB), .LFSR_SEED(8'h01), .CNT_W(8)) u_b (
    .clk(clk), .rst_n(rst_n_bc), .start(start_b), .q(q_b), .dut_rst_n(dut_rst_n_b), .d(d_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b), .first_err_idx(first_b));

  dff_bist #(.NUM_VECTORS(NC), .RST_CYCLES(RC), .LFSR_SEED(8'h00), .CNT_W(4)) u_c (
    .clk(clk), .rst_n(rst_n_bc), .start(start_c), .q(q_c), .dut_rst_n(dut_rst_n_c), .d(d_c),
    .busy(busy_c), .done(done_c), .pass(pass_c), .err_count(err_c), .first_err_idx(first_c));

  always @(posedge clk or negedge dut_rst_n_a)
    if (!dut_rst_n_a) q_a <= 1'b0; else q_a <= d_a;
  always @(posedge clk or negedge dut_rst_n_b)
    if (!dut_rst_n_b) r_b <= 1'b0; else r_b <= (mode_b == 3) ? ~d_b : d_b;
  always @(posedge clk or negedge dut_rst_n_c)
    if (!dut_rst_n_c) r_c <= 1'b0; else r_c <= (mode_c == 3) ? ~d_c : d_c;
  assign q_b = (mode_b == 1) ? 1'b0 : (mode_b == 2) ? 1'b1 : r_b;
  assign q_c = (mode_c == 1) ? 1'b0 : (mode_c == 2) ? 1'b1 : r_c;

  exp_t qa[$], qb[$], qc[$];
  exp_t xa, xb, xc;
  bit   vec_a [1:NA];
  int   a_e = 0;
  bit   a_active = 0;
  int   off_a;
  logic pa = 1'b0, pb = 1'b0, pc = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  // Expected summary of one run: the RUT's observed value per vector versus the bit driven.
  function automatic exp_t model(input int e, input int rst, input int n, input logic [7:0] seed,
                                 input int mode, input int cw);
    exp_t       x;
    logic [7:0] s;
    int         errs, first, cap;
    bit         v, got;
    s     = (seed == 8'h00) ? 8'h01 : seed;
    errs  = (mode == 2) ? 1 : 0;
    first = (mode == 2) ? 0 : -1;
    for (int k = 1; k <= n; k++) begin
      v   = s[0];
      s   = lfsr_next(s);
      got = (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : (mode == 3) ? ~v : v;
      if (got != v) begin
        errs++;
        if (first < 0) first = k;
      end
    end
    cap        = (1 << cw) - 1;
    x.done_cyc = e + rst + n + 2;
    x.err      = (errs > cap) ? cap : errs;
    x.first    = (first < 0) ? 0 : first;
    x.pass     = (errs == 0) ? 1 : 0;
    return x;
  endfunction

  always @(negedge clk) begin
    if (a_active) begin
      off_a = cyc - a_e;
      if (off_a >= 0 && off_a <= RA + NA + 2) begin
        chk("a_rut_rst_n", dut_rst_n_a, (off_a < RA) ? 0 : 1);
        chk("a_d", d_a, (off_a > RA && off_a <= RA + NA) ? int'(vec_a[off_a - RA]) : 0);
        chk("a_busy", busy_a, (off_a < RA + NA + 2) ? 1 : 0);
      end
    end
    if (done_a && !pa) begin
      chk("a_sb_has_entry", int'(qa.size() > 0), 1);
      if (qa.size() > 0) begin
        xa = qa.pop_front();
        chk("a_done_cycle", cyc, xa.done_cyc);
        chk("a_pass", pass_a, xa.pass);
        chk("a_err_count", err_a, xa.err);
        chk("a_first_err_idx", first_a, xa.first);
      end
    end
    if (done_b && !pb) begin
      chk("b_sb_has_entry", int'(qb.size() > 0), 1);
      if (qb.size() > 0) begin
        xb = qb.pop_front();
        chk("b_done_cycle", cyc, xb.done_cyc);
        chk("b_pass", pass_b, xb.pass);
        chk("b_err_count", err_b, xb.err);
        chk("b_first_err_idx", first_b, xb.first);
        chk("b_busy_at_done", busy_b, 0);
      end
    end
    if (done_c && !pc) begin
      chk("c_sb_has_entry", int'(qc.size() > 0), 1);
      if (qc.size() > 0) begin
        xc = qc.pop_front();
        chk("c_done_cycle", cyc, xc.done_cyc);
        chk("c_pass", pass_c, xc.pass);
        chk("c_err_count", err_c, xc.err);
        chk("c_first_err_idx", first_c, xc.first);
      end
    end
    pa = done_a;
    pb = done_b;
    pc = done_c;
  end

  function automatic int sb_size(input int which);
    return (which == 0) ? qa.size() : (which == 1) ? qb.size() : qc.size();
  endfunction

  // Call just after a negedge; the start is sampled at the following posedge.
  task automatic launch(input int which, input int mode);
    int   e;
    exp_t x;
    if (which == 1) mode_b = mode;
    if (which == 2) mode_c = mode;
    if (which == 0) start_a = 1'b1;
    else if (which == 1) start_b = 1'b1;
    else start_c = 1'b1;
    @(posedge clk);
    #1;
    e = cyc;
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
    case (which)
      0: begin
        x = model(e, RA, NA, 8'h01, 0, 8);
        qa.push_back(x);
        a_e = e;
        a_active = 1'b1;
      end
      1: begin
        x = model(e, RB, NB, 8'h01, mode, 8);
        qb.push_back(x);
      end
      default: begin
        x = model(e, RC, NC, 8'h00, mode, 4);
        qc.push_back(x);
      end
    endcase
  endtask

  task automatic wait_empty(input int which);
    int n;
    n = 0;
    while (sb_size(which) != 0 && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (n >= 600) chk("sb_drain_timeout", sb_size(which), 0);
    @(negedge clk);
  endtask

  task automatic check_reset_a(input string tag);
    chk({tag, "_dut_rst_n"}, dut_rst_n_a, 0);
    chk({tag, "_d"}, d_a, 0);
    chk({tag, "_busy"}, busy_a, 0);
    chk({tag, "_done"}, done_a, 0);
    chk({tag, "_pass"}, pass_a, 0);
    chk({tag, "_err_count"}, err_a, 0);
    chk({tag, "_first_err_idx"}, first_a, 0);
  endtask

  initial begin
    logic [7:0] s;
    int         n;
    int         m;
    rst_n_a  = 1'b0;
    rst_n_bc = 1'b0;
    start_a  = 1'b0;
    start_b  = 1'b0;
    start_c  = 1'b0;
    s = 8'h01;
    for (int k = 1; k <= NA; k++) begin
      vec_a[k] = s[0];
      s = lfsr_next(s);
    end
    repeat (3) @(negedge clk);
    check_reset_a("por");
    rst_n_a  = 1'b1;
    rst_n_bc = 1'b1;
    @(negedge clk);
    chk("a_rut_rst_release", dut_rst_n_a, 1);

    repeat ($urandom_range(1, 5)) @(negedge clk);
    launch(0, 0);
    wait_empty(0);

    // A start pulse while busy must leave the run untouched.
    launch(0, 0);
    repeat ($urandom_range(3, 60)) @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    wait_empty(0);

    launch(0, 0);
    repeat ($urandom_range(RA + 3, RA + NA - 2)) @(posedge clk);
    #3 rst_n_a = 1'b0;
    a_active = 1'b0;
    qa.delete();
    #1 check_reset_a("midrun_rst");
    @(negedge clk);
    check_reset_a("held_rst");
    rst_n_a = 1'b1;
    @(negedge clk);
    launch(0, 0);
    wait_empty(0);

    for (int md = 1; md <= 3; md++) begin
      launch(1, md);
      wait_empty(1);
    end

    // Back-to-back: restart in the first DONE cycle after a failing run.
    launch(1, 1);
    n = 0;
    while (!done_b && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_done_seen", int'(n < 600), 1);
    launch(1, 0);
    chk("b2b_done_drop", done_b, 0);
    chk("b2b_busy", busy_b, 1);
    chk("b2b_err_cleared", err_b, 0);
    chk("b2b_first_cleared", first_b, 0);
    chk("b2b_pass_cleared", pass_b, 0);
    wait_empty(1);

    launch(2, 3);
    wait_empty(2);

    repeat (4) begin
      m = int'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) begin
        launch(1, m);
        wait_empty(1);
      end else begin
        launch(2, m);
        wait_empty(2);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dff_bist.md
# dff_bist

Hardware built-in self-test driver/checker for a single-bit D flip-flop register under test (RUT). It sits on the opposite side of the flop's `d`/`q`/reset interface. It drives the RUT reset and a pseudo-random `d` stream, and predicts `q`. It compares the prediction every cycle and reports a pass/fail summary with an error count and the first failing vector index. The block shares `clk` with the RUT and is intended for on-chip self-test of the register cells.

## Interface
- `NUM_VECTORS`, default 64: number of LFSR data vectors driven in RUN; must be ≥ 1.
- `RST_CYCLES`, default 2: cycles `dut_rst_n` is held low in RST_ASSERT; must be ≥ 1.
- `LFSR_SEED`, default 8'h01: initial LFSR value; a seed of 0 is replaced by 8'h01.
- `CNT_W`, default 8: error counter width.
- `IDX_W`, default $clog2(NUM_VECTORS+1): vector index width.
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  system clock, shared with the RUT.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  single-cycle request to begin a test; ignored while `busy`.
- `q`  in  1  RUT output.
- `dut_rst_n`  out  1  active-low reset to the RUT; registered.
- `d`  out  1  data to the RUT; registered.
- `busy`  out  1  high from the start acceptance until DONE.
- `done`  out  1  high in DONE; held until the next accepted `start`.
- `pass`  out  1  valid when `done`; 1 iff `err_count` == 0.
- `err_count`  out  CNT_W  number of mismatches; saturates at 2^CNT_W−1.
- `first_err_idx`  out  IDX_W  index of the first mismatch; 0 = reset check, k = vector k (1-based); 0 if none.

## Operation
- FSM states and transitions:
  - IDLE → RST_ASSERT when `start` is sampled high.
  - RST_ASSERT runs for RST_CYCLES cycles, then → RST_CHK.
  - RST_CHK lasts 1 cycle, then → RUN.
  - RUN lasts NUM_VECTORS cycles, then → DRAIN.
  - DRAIN lasts 1 cycle, then → DONE.
  - DONE → RST_ASSERT on `start`.
- Accepting `start` (from IDLE or DONE) clears `err_count`, `first_err_idx`, `done`, and `pass`, and reloads the LFSR with the seed.
- RST_ASSERT: `dut_rst_n`=0 and `d`=0.
- RST_CHK: `dut_rst_n`=1 and `d`=0. `q` is compared against 0 as check index 0.
- LFSR:
  - 8-bit, update lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
  - Advances once per RUN cycle.
  - `d` register loads lfsr[0] on each edge that enters or stays in RUN. Vector k is the k-th bit driven.
- Prediction: `exp_q` <= `d` every cycle, and `cmp_en` <= (`d` was a RUN vector). Whenever `cmp_en` is high, `q` is compared with `exp_q`. This covers vectors 1..NUM_VECTORS; the last compare happens in DRAIN.
- Mismatch handling: `err_count` increments, saturating. If this is the first mismatch, `first_err_idx` records its index.
- Unused states: `d`=0 in DRAIN, DONE and IDLE. `dut_rst_n`=1 in every state except RST_ASSERT.
- Reset: `rst_n` low at any time, including mid-test, immediately forces IDLE.
- Reset values:
  - `dut_rst_n`=0, so the RUT is held in reset with the BIST. It goes to 1 on the first edge after `rst_n` release.
  - `d`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `first_err_idx`=0.
  - LFSR = seed; internal `exp_q` and `cmp_en` are 0.

## Timing
- Edge 0 samples `start`; `busy`=1 after edge 0.
- `dut_rst_n` is low after edges 0..RST_CYCLES−1.
- Vector 1 appears on `d` after edge RST_CYCLES+1.
- Vector k is captured by the RUT at the next edge and compared one edge later. The check pipeline latency is 2 edges from `d` update to compare.
- `done`=1 and `busy`=0 after edge RST_CYCLES+NUM_VECTORS+2.
- `pass`, `err_count` and `first_err_idx` are stable from that same edge onward.
- `start` while `busy` has no effect. `start` coincident with async reset is lost.
- Back-to-back: `start` in the first DONE cycle is accepted, and `done` drops on the next edge.

## Test plan
- Ideal RUT (async-reset DFF), defaults, pulse `start`:
  - `done` rises 68 cycles after the start edge.
  - `pass`=1, `err_count`=0, `first_err_idx`=0.
  - `d` matches the golden LFSR stream from seed 8'h01.
- `q` stuck-at-0, NUM_VECTORS=255:
  - `err_count`=128, `first_err_idx`=1, `pass`=0.
- `q` stuck-at-1, NUM_VECTORS=255:
  - The reset check fails plus 127 zero vectors: `err_count`=128, `first_err_idx`=0.
- Inverting RUT (q <= ~d, reset 0), NUM_VECTORS=255, CNT_W=8:
  - `err_count`=255, `first_err_idx`=1.
  - Repeat with CNT_W=4: `err_count` saturates at 15.
- Control scenarios:
  - Pulse `start` again mid-RUN: ignored, and the result is identical to an uninterrupted run.
  - Assert `rst_n` low mid-RUN: immediate IDLE with all reset values.
  - Release `rst_n` and start again: `pass`=1.
  - `start` in the first DONE cycle reruns with counters cleared.
